// File: rtl/uart_link_pkg.sv
// Shared command codes, state encoding and framing constants for the
// UART word link.
package uart_link_pkg;

  localparam logic [2:0] CMD_IDLE  = 3'b000;
  localparam logic [2:0] CMD_SEND  = 3'b001;
  localparam logic [2:0] CMD_RECV  = 3'b010;
  localparam logic [2:0] CMD_ABORT = 3'b111;

  localparam int FRAME_BITS     = 10;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    TX_BYTE,
    RX_WAIT,
    RX_BYTE,
    DONE
  } link_state_e;

endpackage

// File: rtl/uart_word_link_if.sv
// Core-side command/data bundle of the UART word link; the core is the
// master, the link stage is the slave.
interface uart_word_link_if;

  logic [2:0]  uartc;
  logic [31:0] uart_out;
  logic [31:0] uart_in;
  logic        wb_flag;
  logic        busy;
  logic        frame_err;

  modport master (
    output uartc, uart_out,
    input  uart_in, wb_flag, busy, frame_err
  );

  modport slave (
    input  uartc, uart_out,
    output uart_in, wb_flag, busy, frame_err
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter with restart; flags the half-period and
// last-cycle points of every bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic half_tick,
  output logic full_tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign full_tick = (cnt == LAST);
  assign half_tick = (cnt == HALF);

endmodule

// File: rtl/uart_word_link.sv
// Executes the core's UART command: send or receive one 32-bit word as four
// 8N1 bytes (LSB first), or abort; completion is held on wb_flag.
module uart_word_link
  import uart_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic rx,
  output logic tx,
  uart_word_link_if.slave core
);

  localparam logic [3:0] LAST_BIT  = 4'(FRAME_BITS - 1);
  localparam logic [3:0] STOP_BIT  = 4'(FRAME_BITS - 2);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  link_state_e state;
  logic [2:0]  cmd;
  logic [31:0] tx_shift;
  logic [7:0]  rx_byte;
  logic [3:0]  bit_idx;
  logic [1:0]  byte_cnt;
  logic [31:0] uart_in_q;
  logic        wb_q;
  logic        busy_q;
  logic        ferr_q;

  logic rx_meta;
  logic rx_sync;
  logic rx_prev;
  logic rx_fall;

  logic tx_restart;
  logic tx_tick;
  logic tx_half_unused;
  logic rx_restart;
  logic rx_half;
  logic rx_full;

  assign cmd = core.uartc;

  // rx is asynchronous: two flops for metastability, a third for edge detect
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  assign tx_restart = (state == IDLE) && (cmd == CMD_SEND);
  // The RX timer restarts on the start edge and again at mid start bit, so
  // every later full tick lands in the middle of a data or stop bit.
  assign rx_restart = ((state == RX_WAIT) && rx_fall) ||
                      ((state == RX_BYTE) && (bit_idx == 4'd0) && rx_half && !rx_sync);

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
    .clock     (clock),
    .reset     (reset),
    .restart   (tx_restart),
    .half_tick (tx_half_unused),
    .full_tick (tx_tick)
  );

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
    .clock     (clock),
    .reset     (reset),
    .restart   (rx_restart),
    .half_tick (rx_half),
    .full_tick (rx_full)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      tx        <= 1'b1;
      tx_shift  <= '0;
      rx_byte   <= '0;
      bit_idx   <= '0;
      byte_cnt  <= '0;
      uart_in_q <= '0;
      wb_q      <= 1'b0;
      busy_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          case (cmd)
            CMD_SEND: begin
              tx_shift <= core.uart_out;
              byte_cnt <= '0;
              bit_idx  <= '0;
              tx       <= 1'b0;
              busy_q   <= 1'b1;
              state    <= TX_BYTE;
            end
            CMD_RECV: begin
              ferr_q   <= 1'b0;
              byte_cnt <= '0;
              bit_idx  <= '0;
              busy_q   <= 1'b1;
              state    <= RX_WAIT;
            end
            CMD_ABORT: state <= DONE;
            default: ;
          endcase
        end

        // bit_idx names the bit currently on the line: 0 start, 1..8 data, 9 stop
        TX_BYTE: begin
          if (cmd == CMD_ABORT) begin
            tx     <= 1'b1;
            busy_q <= 1'b0;
            state  <= DONE;
          end else if (tx_tick) begin
            if (bit_idx == LAST_BIT) begin
              if (byte_cnt == LAST_BYTE) begin
                busy_q <= 1'b0;
                state  <= DONE;
              end else begin
                byte_cnt <= byte_cnt + 2'd1;
                bit_idx  <= '0;
                tx       <= 1'b0;
              end
            end else if (bit_idx == STOP_BIT) begin
              tx      <= 1'b1;
              bit_idx <= bit_idx + 4'd1;
            end else begin
              tx       <= tx_shift[0];
              tx_shift <= tx_shift >> 1;
              bit_idx  <= bit_idx + 4'd1;
            end
          end
        end

        RX_WAIT: begin
          if (cmd == CMD_ABORT) begin
            busy_q <= 1'b0;
            state  <= DONE;
          end else if (rx_fall) begin
            bit_idx <= '0;
            state   <= RX_BYTE;
          end
        end

        RX_BYTE: begin
          if (cmd == CMD_ABORT) begin
            busy_q <= 1'b0;
            state  <= DONE;
          end else if (bit_idx == 4'd0) begin
            if (rx_half) begin
              if (rx_sync) begin
                state <= RX_WAIT;
              end else begin
                bit_idx <= 4'd1;
              end
            end
          end else if (rx_full) begin
            if (bit_idx == LAST_BIT) begin
              // A bad stop bit is flagged but the byte is kept.
              uart_in_q[{byte_cnt, 3'b000} +: 8] <= rx_byte;
              if (!rx_sync) begin
                ferr_q <= 1'b1;
              end
              if (byte_cnt == LAST_BYTE) begin
                busy_q <= 1'b0;
                state  <= DONE;
              end else begin
                byte_cnt <= byte_cnt + 2'd1;
                state    <= RX_WAIT;
              end
            end else begin
              rx_byte <= {rx_sync, rx_byte[7:1]};
              bit_idx <= bit_idx + 4'd1;
            end
          end
        end

        // wb_flag rises one cycle after entry and holds until the core idles
        DONE: begin
          tx <= 1'b1;
          if (!wb_q) begin
            wb_q <= 1'b1;
          end else if (cmd == CMD_IDLE) begin
            wb_q  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign core.uart_in   = uart_in_q;
  assign core.wb_flag   = wb_q;
  assign core.busy      = busy_q;
  assign core.frame_err = ferr_q;

endmodule

// File: tb/tb_uart_word_link.sv
// Randomized bench for uart_word_link: a bit-level line model drives and
// predicts the serial side while one process compares outputs every cycle.
module tb_uart_word_link;
  import uart_link_pkg::*;

  localparam int CPB = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic rx    = 1'b1;
  logic tx;

  uart_word_link_if core ();

  uart_word_link #(.CLKS_PER_BIT(CPB)) dut (
    .clock (clock),
    .reset (reset),
    .rx    (rx),
    .tx    (tx),
    .core  (core)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic        exp_tx      = 1'b1;
  logic        exp_busy    = 1'b0;
  logic        exp_wb      = 1'b0;
  logic        exp_ferr    = 1'b0;
  logic [31:0] exp_uart_in = '0;
  bit chk_en   = 1'b0;
  bit chk_wb   = 1'b1;
  bit chk_busy = 1'b1;
  bit chk_data = 1'b1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s t=%0t got=%h want=%h", name, $time, act, req);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Outputs are compared mid-cycle against the line model's expectations
  always @(negedge clock) begin
    if (chk_en) begin
      check_output("tx", 32'(tx), 32'(exp_tx));
      if (chk_busy) check_output("busy", 32'(core.busy), 32'(exp_busy));
      if (chk_wb)   check_output("wb_flag", 32'(core.wb_flag), 32'(exp_wb));
      if (chk_data) begin
        check_output("uart_in", core.uart_in, exp_uart_in);
        check_output("frame_err", 32'(core.frame_err), 32'(exp_ferr));
      end
    end
  end

  task automatic send_word(input logic [31:0] w, input int hold, input int abort_n, input bit capture);
    logic       bits [40];
    logic       seen [40];
    logic [7:0] lit  [4];
    logic [7:0] dec;
    int         rise;
    int         chg_n;
    bit         aborted;
    rise    = -1;
    aborted = 1'b0;
    chg_n   = $urandom_range(CPB, 30 * CPB);
    for (int b = 0; b < 4; b++) begin
      bits[10*b] = 1'b0;
      for (int i = 0; i < 8; i++) bits[10*b+1+i] = w[8*b+i];
      bits[10*b+9] = 1'b1;
    end
    for (int i = 0; i < 40; i++) seen[i] = 1'bx;
    core.uart_out = w;
    core.uartc    = CMD_SEND;
    step();
    exp_tx = bits[0]; exp_busy = 1'b1; exp_wb = 1'b0;
    core.uart_out = $urandom();
    for (int n = 1; n < 40 * CPB; n++) begin
      if (n == abort_n) begin
        core.uartc = CMD_ABORT;
        step();
        exp_tx = 1'b1; exp_busy = 1'b0;
        step();
        exp_wb  = 1'b1;
        aborted = 1'b1;
        break;
      end
      if (abort_n < 0 && n == chg_n) core.uartc = ($urandom_range(0, 1) == 0) ? CMD_RECV : 3'b011;
      if (abort_n < 0 && n == chg_n + 3) core.uartc = CMD_SEND;
      step();
      exp_tx = bits[n / CPB];
      if (capture && (n % CPB) == CPB / 2) seen[n / CPB] = tx;
      if (core.wb_flag === 1'b1 && rise < 0) rise = n;
    end
    if (!aborted) begin
      step();
      exp_tx = 1'b1; exp_busy = 1'b0;
      if (core.wb_flag === 1'b1 && rise < 0) rise = 40 * CPB;
      step();
      exp_wb = 1'b1;
      if (core.wb_flag === 1'b1 && rise < 0) rise = 40 * CPB + 1;
    end
    if (capture) begin
      lit[0] = 8'hEF; lit[1] = 8'hBE; lit[2] = 8'hAD; lit[3] = 8'hDE;
      check_output("send_latency", rise, 161);
      for (int b = 0; b < 4; b++) begin
        for (int i = 0; i < 8; i++) dec[i] = seen[10*b+1+i];
        check_output("tx_byte", 32'(dec), 32'(lit[b]));
        check_output("tx_start", 32'(seen[10*b]), 0);
        check_output("tx_stop", 32'(seen[10*b+9]), 1);
      end
    end
    for (int h = 0; h < hold; h++) step();
    core.uartc = CMD_IDLE;
    step();
    exp_wb = 1'b0;
    step();
  endtask

  task automatic recv_word(input logic [31:0] w, input logic [3:0] stops,
                           input logic [3:0] glitches, input int reset_byte);
    logic [9:0] frame;
    bit         found;
    core.uartc = CMD_RECV;
    step();
    exp_busy = 1'b1; exp_ferr = 1'b0;
    step();
    chk_data = 1'b0;
    for (int b = 0; b < 4; b++) begin
      rx = 1'b1;
      repeat ($urandom_range(1, 4)) step();
      if (glitches[b]) begin
        rx = 1'b0;
        step();
        rx = 1'b1;
        repeat (CPB + 4) step();
      end
      frame = {stops[b], w[8*b +: 8], 1'b0};
      for (int i = 0; i < 10; i++) begin
        if (b == 3 && i == 9) begin
          chk_wb = 1'b0; chk_busy = 1'b0;
        end
        if (b == reset_byte && i == 4) begin
          chk_en = 1'b0;
          #2;
          reset      = 1'b0;
          core.uartc = CMD_IDLE;
          rx         = 1'b1;
          #1;
          check_output("rst_uart_in", core.uart_in, 0);
          check_output("rst_busy", 32'(core.busy), 0);
          check_output("rst_tx", 32'(tx), 1);
          exp_tx = 1'b1; exp_busy = 1'b0; exp_wb = 1'b0; exp_ferr = 1'b0; exp_uart_in = '0;
          chk_wb = 1'b1; chk_busy = 1'b1; chk_data = 1'b1; chk_en = 1'b1;
          step();
          step();
          reset = 1'b1;
          step();
          return;
        end
        rx = frame[i];
        repeat (CPB) step();
      end
    end
    rx    = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 4 * CPB + 8 && !found; k++) begin
      if (core.wb_flag === 1'b1) found = 1'b1;
      else step();
    end
    check_output("rx_done", 32'(core.wb_flag), 1);
    exp_wb = 1'b1; exp_busy = 1'b0; exp_uart_in = w; exp_ferr = ~&stops;
    chk_wb = 1'b1; chk_busy = 1'b1; chk_data = 1'b1;
    repeat ($urandom_range(1, 6)) step();
    core.uartc = CMD_IDLE;
    step();
    exp_wb = 1'b0;
    step();
  endtask

  task automatic apply_stimulus();
    logic [3:0] stops;
    core.uartc    = CMD_IDLE;
    core.uart_out = '0;
    #12;
    check_output("reset_tx", 32'(tx), 1);
    check_output("reset_uart_in", core.uart_in, 0);
    check_output("reset_wb", 32'(core.wb_flag), 0);
    check_output("reset_busy", 32'(core.busy), 0);
    check_output("reset_ferr", 32'(core.frame_err), 0);
    step();
    reset  = 1'b1;
    chk_en = 1'b1;
    repeat (3) step();

    send_word(32'hDEADBEEF, 339, -1, 1'b1);

    recv_word(32'h12345678, 4'hF, 4'b0010, -1);
    check_output("rx_word_literal", core.uart_in, 32'h12345678);
    check_output("rx_ferr_clean", 32'(core.frame_err), 0);

    recv_word($urandom(), 4'b1011, 4'b0101, -1);
    check_output("rx_ferr_set", 32'(core.frame_err), 1);

    send_word($urandom(), 6, 10 * CPB + $urandom_range(0, 10 * CPB - 1), 1'b0);

    recv_word($urandom(), 4'hF, 4'h0, 2);
    recv_word($urandom(), 4'hF, 4'b1000, -1);

    // Abort from idle completes without going busy
    core.uartc = CMD_ABORT;
    step();
    step();
    exp_wb = 1'b1;
    repeat (3) step();
    core.uartc = CMD_IDLE;
    step();
    exp_wb = 1'b0;
    core.uartc = 3'b101;
    repeat (6) step();
    core.uartc = CMD_IDLE;
    step();

    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        send_word($urandom(), $urandom_range(0, 5),
                  ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40 * CPB - 1) : -1, 1'b0);
      end else begin
        stops = 4'hF;
        if ($urandom_range(0, 2) == 0) stops[$urandom_range(0, 3)] = 1'b0;
        recv_word($urandom(), stops, 4'($urandom_range(0, 15)), -1);
      end
    end
  endtask

  initial begin
    apply_stimulus();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
